// File: rtl/arcade_video_timing.sv
// arcade_video_timing
// Raster timing generator for arcade cores. Divides clk_video into a one-cycle
// pixel enable, runs the horizontal/vertical pixel counters and produces
// registered blank, sync and frame_start, all aligned with ce_pix.
//
// Optional feature macro: ARCADE_TIMING_ADJUST_EN
//   defined   - h_adj/v_adj are latched at the start of each frame and nudge
//               the HSync/VSync start position (clamped inside blanking).
//   undefined - adjust inputs are ignored; sync starts at the front-porch end.

module arcade_video_timing #(
    parameter  int unsigned CE_DIV   = 4,
    parameter  int unsigned H_ACTIVE = 256,
    parameter  int unsigned H_FP     = 8,
    parameter  int unsigned H_SYNC   = 32,
    parameter  int unsigned H_BP     = 88,
    parameter  int unsigned V_ACTIVE = 224,
    parameter  int unsigned V_FP     = 8,
    parameter  int unsigned V_SYNC   = 8,
    parameter  int unsigned V_BP     = 24,
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW       = $clog2(H_TOTAL),
    localparam int unsigned VW       = $clog2(V_TOTAL)
) (
    input  logic          clk_video,
    input  logic          reset_n,
    input  logic [3:0]    h_adj,
    input  logic [3:0]    v_adj,
    output logic          ce_pix,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          HBlank,
    output logic          VBlank,
    output logic          HSync,
    output logic          VSync,
    output logic          frame_start
);

    localparam int unsigned DW  = $clog2(CE_DIV);
    localparam int unsigned HSW = HW + 1;
    localparam int unsigned VSW = VW + 1;

    // Divider and position
    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          tick;
    logic          line_wrap;
    logic          frame_wrap;

    // Registered outputs
    logic ce_q, ce_d;
    logic hb_q, hb_d;
    logic vb_q, vb_d;
    logic hs_q, hs_d;
    logic vs_q, vs_d;
    logic fs_q, fs_d;

    // Sync placement
    logic signed [3:0]     h_off;
    logic signed [3:0]     v_off;
    logic signed [HSW-1:0] hs_raw;
    logic signed [VSW-1:0] vs_raw;
    logic [HSW-1:0]        hs_start;
    logic [HSW-1:0]        hs_end;
    logic [VSW-1:0]        vs_start;
    logic [VSW-1:0]        vs_end;

    assign tick       = (div_q == DW'(CE_DIV - 1));
    assign line_wrap  = (h_q == HW'(H_TOTAL - 1));
    assign frame_wrap = tick && line_wrap && (v_q == VW'(V_TOTAL - 1));

`ifdef ARCADE_TIMING_ADJUST_EN
    logic [3:0] h_adj_q, h_adj_d;
    logic [3:0] v_adj_q, v_adj_d;

    // Capture the adjust inputs only on the tick that lands on (0,0)
    always_comb begin
        h_adj_d = h_adj_q;
        v_adj_d = v_adj_q;
        if (frame_wrap) begin
            h_adj_d = h_adj;
            v_adj_d = v_adj;
        end
    end

    // Per-frame adjust latches
    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            h_adj_q <= '0;
            v_adj_q <= '0;
        end else begin
            h_adj_q <= h_adj_d;
            v_adj_q <= v_adj_d;
        end
    end

    assign h_off = $signed(h_adj_q);
    assign v_off = $signed(v_adj_q);
`else
    logic unused_adj;

    assign unused_adj = ^{h_adj, v_adj};
    assign h_off      = '0;
    assign v_off      = '0;
`endif

    // Sync start = nominal + signed offset, clamped so sync stays inside blanking.
    // The offset is sign-extended into a signed sum one bit wider than the counter.
    always_comb begin
        hs_raw = $signed(HSW'(H_ACTIVE + H_FP)) + HSW'(h_off);
        if (hs_raw < $signed(HSW'(H_ACTIVE))) begin
            hs_start = HSW'(H_ACTIVE);
        end else if (hs_raw > $signed(HSW'(H_TOTAL - H_SYNC))) begin
            hs_start = HSW'(H_TOTAL - H_SYNC);
        end else begin
            hs_start = $unsigned(hs_raw);
        end
        hs_end = hs_start + HSW'(H_SYNC);

        vs_raw = $signed(VSW'(V_ACTIVE + V_FP)) + VSW'(v_off);
        if (vs_raw < $signed(VSW'(V_ACTIVE))) begin
            vs_start = VSW'(V_ACTIVE);
        end else if (vs_raw > $signed(VSW'(V_TOTAL - V_SYNC))) begin
            vs_start = VSW'(V_TOTAL - V_SYNC);
        end else begin
            vs_start = $unsigned(vs_raw);
        end
        vs_end = vs_start + VSW'(V_SYNC);
    end

    // Next divider value and next raster position
    always_comb begin
        div_d = tick ? '0 : div_q + DW'(1);
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            if (line_wrap) begin
                h_d = '0;
                v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
        end
    end

    // Output decode from the new position, so outputs move with ce_pix
    always_comb begin
        ce_d = tick;
        fs_d = frame_wrap;
        hb_d = hb_q;
        vb_d = vb_q;
        hs_d = hs_q;
        vs_d = vs_q;
        if (tick) begin
            hb_d = (h_d >= HW'(H_ACTIVE));
            vb_d = (v_d >= VW'(V_ACTIVE));
            hs_d = (HSW'(h_d) >= hs_start) && (HSW'(h_d) < hs_end);
            if (line_wrap) begin
                vs_d = (VSW'(v_d) >= vs_start) && (VSW'(v_d) < vs_end);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
            ce_q  <= 1'b0;
            hb_q  <= 1'b0;
            vb_q  <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
            ce_q  <= ce_d;
            hb_q  <= hb_d;
            vb_q  <= vb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            fs_q  <= fs_d;
        end
    end

    assign ce_pix      = ce_q;
    assign hcount      = h_q;
    assign vcount      = v_q;
    assign HBlank      = hb_q;
    assign VBlank      = vb_q;
    assign HSync       = hs_q;
    assign VSync       = vs_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_arcade_video_timing.sv
// Bench for arcade_video_timing.
// Instance A uses the default raster (line-level timing); instance B uses a
// small raster (CE_DIV=2, 28x18, H_FP=2) so whole frames, adjust and clamping
// fit in a short run. Expected pixels are queued per stimulus and popped by a
// monitor on every ce_pix.

module tb_arcade_video_timing;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hb;
        logic       vb;
        logic       hs;
        logic       vs;
        logic       fs;
    } pix_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    // Instance A: default parameters
    logic       rst_a;
    logic [3:0] h_adj_a, v_adj_a;
    logic       ce_a, hb_a, vb_a, hs_a, vs_a, fs_a;
    logic [8:0] hcount_a, vcount_a;

    arcade_video_timing u_a (
        .clk_video  (clk),
        .reset_n    (rst_a),
        .h_adj      (h_adj_a),
        .v_adj      (v_adj_a),
        .ce_pix     (ce_a),
        .hcount     (hcount_a),
        .vcount     (vcount_a),
        .HBlank     (hb_a),
        .VBlank     (vb_a),
        .HSync      (hs_a),
        .VSync      (vs_a),
        .frame_start(fs_a)
    );

    // Instance B: H_TOTAL=28, V_TOTAL=18, CE_DIV=2
    logic       rst_b;
    logic [3:0] h_adj_b, v_adj_b;
    logic       ce_b, hb_b, vb_b, hs_b, vs_b, fs_b;
    logic [4:0] hcount_b, vcount_b;

    arcade_video_timing #(
        .CE_DIV  (2),
        .H_ACTIVE(16),
        .H_FP    (2),
        .H_SYNC  (4),
        .H_BP    (6),
        .V_ACTIVE(8),
        .V_FP    (2),
        .V_SYNC  (2),
        .V_BP    (6)
    ) u_b (
        .clk_video  (clk),
        .reset_n    (rst_b),
        .h_adj      (h_adj_b),
        .v_adj      (v_adj_b),
        .ce_pix     (ce_b),
        .hcount     (hcount_b),
        .vcount     (vcount_b),
        .HBlank     (hb_b),
        .VBlank     (vb_b),
        .HSync      (hs_b),
        .VSync      (vs_b),
        .frame_start(fs_b)
    );

    pix_t qa[$];
    int   qa_k[$];
    pix_t qb[$];
    int   qb_k[$];
    int   fs_times[$];

    // Expected pixel k after reset release (k=1 is the first ce_pix).
    function automatic pix_t mk(int k, int ht, int vt, int ha, int va,
                                int hs0, int hsw, int vs0, int vsw);
        pix_t p;
        int h, v;
        h    = k % ht;
        v    = (k / ht) % vt;
        p.h  = 10'(h);
        p.v  = 10'(v);
        p.hb = (h >= ha);
        p.vb = (v >= va);
        p.hs = (h >= hs0) && (h < hs0 + hsw);
        p.vs = (v >= vs0) && (v < vs0 + vsw);
        p.fs = (h == 0) && (v == 0);
        return p;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor for A
    always @(negedge clk) begin
        if (rst_a && ce_a && qa.size() > 0) begin
            pix_t e, g;
            int   k;
            e    = qa.pop_front();
            k    = qa_k.pop_front();
            g.h  = 10'(hcount_a);
            g.v  = 10'(vcount_a);
            g.hb = hb_a;
            g.vb = vb_a;
            g.hs = hs_a;
            g.vs = vs_a;
            g.fs = fs_a;
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL sb_a pixel k=%0d: got h=%0d v=%0d hb,vb,hs,vs,fs=%b expected h=%0d v=%0d hb,vb,hs,vs,fs=%b",
                         k, g.h, g.v, {g.hb, g.vb, g.hs, g.vs, g.fs},
                         e.h, e.v, {e.hb, e.vb, e.hs, e.vs, e.fs});
            end
        end
    end

    // Scoreboard monitor for B
    always @(negedge clk) begin
        if (rst_b && ce_b && qb.size() > 0) begin
            pix_t e, g;
            int   k;
            e    = qb.pop_front();
            k    = qb_k.pop_front();
            g.h  = 10'(hcount_b);
            g.v  = 10'(vcount_b);
            g.hb = hb_b;
            g.vb = vb_b;
            g.hs = hs_b;
            g.vs = vs_b;
            g.fs = fs_b;
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL sb_b pixel k=%0d: got h=%0d v=%0d hb,vb,hs,vs,fs=%b expected h=%0d v=%0d hb,vb,hs,vs,fs=%b",
                         k, g.h, g.v, {g.hb, g.vb, g.hs, g.vs, g.fs},
                         e.h, e.v, {e.hb, e.vb, e.hs, e.vs, e.fs});
            end
        end
    end

    // frame_start timestamps for B
    always @(negedge clk) begin
        if (rst_b && fs_b) fs_times.push_back(cyc);
    end

    initial begin
        int n, g, t0, t1;
        int hb_rise, hs_first, hs_last, leak;
        logic pb, ps;
        int ph;
        int b1_hs0, b1_vs0;

`ifdef ARCADE_TIMING_ADJUST_EN
        b1_hs0 = 16;  // 16+2-8 = 10, clamped up to H_ACTIVE
        b1_vs0 = 16;  // 8+2+7 = 17, clamped down to V_TOTAL-V_SYNC
`else
        b1_hs0 = 18;
        b1_vs0 = 10;
`endif

        rst_a   = 1'b0;
        rst_b   = 1'b0;
        h_adj_a = 4'd7;
        v_adj_a = 4'b1000;
        h_adj_b = 4'd0;
        v_adj_b = 4'd0;

        // ---------------- Instance A: default raster ----------------
        repeat (10) @(negedge clk);
        chk("a_reset_outputs",
            int'({ce_a, hcount_a, vcount_a, hb_a, vb_a, hs_a, vs_a, fs_a}), 0);
        chk("b_reset_outputs",
            int'({ce_b, hcount_b, vcount_b, hb_b, vb_b, hs_b, vs_b, fs_b}), 0);

        for (int k = 1; k <= 400; k++) begin
            qa.push_back(mk(k, 384, 264, 256, 224, 264, 32, 232, 8));
            qa_k.push_back(k);
        end
        rst_a = 1'b1;

        n = 0;
        do begin @(negedge clk); n++; end while (!ce_a && n < 20);
        chk("a_first_ce_latency", n, 4);

        for (int i = 0; i < 8; i++) begin
            g = 0;
            do begin @(negedge clk); g++; end while (!ce_a && g < 20);
            chk("a_ce_period", g, 4);
        end

        n = 0;
        do begin @(negedge clk); n++; end while (!(ce_a && hcount_a == 9'd0) && n < 4000);
        chk("a_first_line_wrap_seen", int'(n < 4000), 1);
        t0 = cyc;
        chk("a_vcount_after_wrap", int'(vcount_a), 1);

        hb_rise  = -1;
        hs_first = -1;
        hs_last  = -1;
        leak     = 0;
        pb       = hb_a;
        ps       = hs_a;
        ph       = int'(hcount_a);
        n        = 0;
        do begin
            @(negedge clk);
            n++;
            if (ce_a) begin
                if (hb_a && !pb) hb_rise = int'(hcount_a);
                if (hs_a && !ps) hs_first = int'(hcount_a);
                if (!hs_a && ps) hs_last = ph;
                if (hs_a && !hb_a) leak++;
                pb = hb_a;
                ps = hs_a;
                ph = int'(hcount_a);
            end
        end while (!(ce_a && hcount_a == 9'd0) && n < 4000);
        t1 = cyc;
        chk("a_line_period", t1 - t0, 1536);
        chk("a_vcount_second_wrap", int'(vcount_a), 2);
        chk("a_hblank_rise_at", hb_rise, 256);
        chk("a_hsync_first", hs_first, 264);
        chk("a_hsync_last", hs_last, 295);
        chk("a_hsync_outside_blank", leak, 0);

        n = 0;
        while (qa.size() > 0 && n < 2000) begin @(negedge clk); n++; end
        chk("a_scoreboard_drained", qa.size(), 0);
        rst_a = 1'b0;

        // ---------------- Instance B: small raster ----------------
        for (int k = 1; k <= 503; k++) begin
            qb.push_back(mk(k, 28, 18, 16, 8, 18, 4, 10, 2));
            qb_k.push_back(k);
        end
        rst_b = 1'b1;

        // Mid-frame adjust change: frame 0 keeps nominal sync, frame 1 moves.
        repeat (400) @(negedge clk);
        h_adj_b = 4'b1000;
        v_adj_b = 4'd7;
        for (int k = 504; k <= 1007; k++) begin
            qb.push_back(mk(k, 28, 18, 16, 8, b1_hs0, 4, b1_vs0, 2));
            qb_k.push_back(k);
        end

        n = 0;
        while (qb.size() > 0 && n < 3000) begin @(negedge clk); n++; end
        chk("b_scoreboard_drained", qb.size(), 0);

        n = 0;
        do begin @(negedge clk); n++; end while (vcount_b != 5'd5 && n < 2000);
        chk("b_reached_line5", int'(vcount_b), 5);

        chk("b_frame_start_count", fs_times.size(), 2);
        if (fs_times.size() >= 2) chk("b_frame_period", fs_times[1] - fs_times[0], 1008);

        // Asynchronous reset in the middle of a clock phase
        #2 rst_b = 1'b0;
        #1;
        chk("b_async_reset_outputs",
            int'({ce_b, hcount_b, vcount_b, hb_b, vb_b, hs_b, vs_b, fs_b}), 0);
        qb.delete();
        qb_k.delete();
        repeat (3) @(negedge clk);

        // Latched adjust is back to 0 after reset even though inputs still hold -8/+7
        for (int k = 1; k <= 60; k++) begin
            qb.push_back(mk(k, 28, 18, 16, 8, 18, 4, 10, 2));
            qb_k.push_back(k);
        end
        rst_b = 1'b1;
        n = 0;
        while (qb.size() > 0 && n < 500) begin @(negedge clk); n++; end
        chk("b_post_reset_drained", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
